// File: rtl/samp_pixel_streamer.sv
// ---------------------------------------------------------------------------
// samp_pixel_streamer
//   Transmit-side pixel source for the sampling layer. The host loads one
//   IMG_W x IMG_H feature map into an internal buffer while the block is idle.
//   On start the block pulses Input_Reset, streams every pixel in raster
//   order under Input_Valid (Input_Finish on the last one), then waits for
//   the layer's Output_Finish and reports done, or err on timeout.
//
// Ports
//   h_clk          in   clock, all logic on the rising edge
//   h_rst_n        in   synchronous active-low reset
//   wr_en          in   host buffer write strobe (honoured only in IDLE)
//   wr_addr        in   host write address (writes at or beyond N dropped)
//   wr_data        in   host write data
//   start          in   begin a frame (level, acted on only in IDLE)
//   hold           in   pause pixel emission (only meaningful in STREAM)
//   Output_Finish  in   layer frame-complete indication
//   Input_Pixel    out  pixel to layer
//   Input_Valid    out  Input_Pixel valid this cycle
//   Input_Finish   out  last pixel of the frame, coincident with Input_Valid
//   Input_Reset    out  one-cycle frame-start pulse to the layer
//   busy           out  high in every state except IDLE
//   done           out  one-cycle completion pulse
//   err            out  sticky timeout flag, cleared by the next start
//
// State      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; host may write the buffer
// S_RST      | Input_Reset cycle; pixel 0 is read and launched here
// S_STREAM   | one pixel per cycle unless hold; last pixel goes to WAIT_FIN
// S_WAIT_FIN | waiting for Output_Finish (or an early one) with timeout
// S_DONE     | done pulse cycle, then back to IDLE
//
// All outputs come straight from registers: each r_* output register is
// loaded with the value the output must show in the cycle after the edge.
// ---------------------------------------------------------------------------
module samp_pixel_streamer #(
  parameter int DATA_W  = 16,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic              h_clk,
  input  logic              h_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              hold,
  input  logic              Output_Finish,
  output logic [DATA_W-1:0] Input_Pixel,
  output logic              Input_Valid,
  output logic              Input_Finish,
  output logic              Input_Reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N     = IMG_W * IMG_H;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_CMP    = (ADDR_W + 1)'(N);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem [N];
  logic [DATA_W-1:0] r_pix;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_fin_seen, w_fin_seen_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_finish, w_finish_nxt;
  logic              r_reset_p, w_reset_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_emit;
  logic              w_last;
  logic              w_wr_ok;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_wr_ok = wr_en && (r_state == S_IDLE) && ({1'b0, wr_addr} < N_CMP);

  // Buffer contents survive reset so a frame can be replayed after an abort.
  always_ff @(posedge h_clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Synchronous read: the pixel register only loads on an emit, so during
  // hold (and after the frame) Input_Pixel keeps the last pixel sent.
  always_ff @(posedge h_clk) begin
    if (!h_rst_n) begin
      r_pix <= '0;
    end else if (w_emit) begin
      r_pix <= r_mem[r_idx[IDX_W-1:0]];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_tmo_nxt      = r_tmo;
    w_fin_seen_nxt = r_fin_seen;
    w_err_nxt      = r_err;
    w_emit         = 1'b0;
    w_valid_nxt    = 1'b0;
    w_finish_nxt   = 1'b0;
    w_reset_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt    = S_RST;
          w_reset_nxt    = 1'b1;
          w_busy_nxt     = 1'b1;
          w_err_nxt      = 1'b0;
          w_idx_nxt      = '0;
          w_fin_seen_nxt = 1'b0;
        end
      end
      // Pixel 0 launches on the RST edge regardless of hold, so it lands
      // in the cycle right after Input_Reset.
      S_RST: begin
        w_emit = 1'b1;
      end
      S_STREAM: begin
        if (Output_Finish) begin
          w_fin_seen_nxt = 1'b1;
        end
        w_emit = !hold;
      end
      S_WAIT_FIN: begin
        if (Output_Finish || r_fin_seen) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (r_tmo == '0) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_tmo_nxt = r_tmo - TMO_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_emit) begin
      w_valid_nxt = 1'b1;
      if (w_last) begin
        w_finish_nxt = 1'b1;
        w_tmo_nxt    = TMO_LOAD;
        w_state_nxt  = S_WAIT_FIN;
      end else begin
        w_idx_nxt   = r_idx + ADDR_W'(1);
        w_state_nxt = S_STREAM;
      end
    end
  end

  always_ff @(posedge h_clk) begin
    if (!h_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_fin_seen <= 1'b0;
      r_valid    <= 1'b0;
      r_finish   <= 1'b0;
      r_reset_p  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_tmo      <= w_tmo_nxt;
      r_fin_seen <= w_fin_seen_nxt;
      r_valid    <= w_valid_nxt;
      r_finish   <= w_finish_nxt;
      r_reset_p  <= w_reset_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign Input_Pixel  = r_pix;
  assign Input_Valid  = r_valid;
  assign Input_Finish = r_finish;
  assign Input_Reset  = r_reset_p;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_samp_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_samp_pixel_streamer
//   Scoreboard bench for samp_pixel_streamer on a 4x4 map with TIMEOUT=8.
//   The driver computes, per frame, the cycle at which every pixel, the
//   Input_Reset pulse and the done pulse must appear (from the frame's start
//   edge, its hold plan and its Output_Finish edge) and queues them. The
//   monitor pops and compares whenever the DUT presents one of those events.
// ---------------------------------------------------------------------------
module tb_samp_pixel_streamer;

  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int AW  = 5;
  localparam int TMO = 8;
  localparam int N   = IW * IH;

  logic          h_clk = 1'b0;
  logic          h_rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          hold;
  logic          Output_Finish;
  logic [DW-1:0] Input_Pixel;
  logic          Input_Valid;
  logic          Input_Finish;
  logic          Input_Reset;
  logic          busy;
  logic          done;
  logic          err;

  samp_pixel_streamer #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH),
    .ADDR_W (AW),
    .TIMEOUT(TMO)
  ) dut (
    .h_clk        (h_clk),
    .h_rst_n      (h_rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .hold         (hold),
    .Output_Finish(Output_Finish),
    .Input_Pixel  (Input_Pixel),
    .Input_Valid  (Input_Valid),
    .Input_Finish (Input_Finish),
    .Input_Reset  (Input_Reset),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 h_clk = ~h_clk;

  int cyc = 0;
  always @(posedge h_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] pix;
    logic          fin;
    int            t;
  } exp_t;

  exp_t          pix_q[$];
  int            rst_q[$];
  int            done_q[$];
  logic [DW-1:0] ref_mem [N];
  bit            hold_plan [64];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int act_cyc);
    n_vec++;
    n_mis++;
    $display("FAIL %s: event at cycle %0d, required none", nm, act_cyc);
  endtask

  // ------------------------------------------------------------ monitor
  logic [DW-1:0] mon_last = '0;
  bit            rst_prev = 1'b0;
  exp_t          ment;
  int            mt;

  always @(negedge h_clk) begin
    if (rst_prev) mon_last = '0;
    rst_prev = (h_rst_n == 1'b0);
    if (Input_Valid === 1'b1) begin
      chk("valid_with_reset", 32'(Input_Reset), 32'd0);
      if (pix_q.size() == 0) begin
        miss("pix_unexpected", cyc);
      end else begin
        ment = pix_q.pop_front();
        chk("pix_data", 32'(Input_Pixel), 32'(ment.pix));
        chk("pix_finish", 32'(Input_Finish), 32'(ment.fin));
        chk("pix_cycle", cyc, ment.t);
      end
      mon_last = Input_Pixel;
    end else if (Input_Valid === 1'b0) begin
      chk("finish_wo_valid", 32'(Input_Finish), 32'd0);
      chk("pix_held", 32'(Input_Pixel), 32'(mon_last));
    end
    if (Input_Reset === 1'b1) begin
      if (rst_q.size() == 0) miss("reset_unexpected", cyc);
      else begin
        mt = rst_q.pop_front();
        chk("reset_cycle", cyc, mt);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) miss("done_unexpected", cyc);
      else begin
        mt = done_q.pop_front();
        chk("done_cycle", cyc, mt);
      end
    end
  end

  // ------------------------------------------------------------ driver
  task automatic step();
    @(posedge h_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; wr_en = 1'b0; Output_Finish = 1'b0;
      hold = 1'($urandom_range(0, 1));
      step();
    end
    hold = 1'b0;
  endtask

  task automatic host_wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    if (a < N) ref_mem[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic gen_hold(input int pct);
    int holds;
    holds = 0;
    for (int i = 0; i < 64; i++) begin
      hold_plan[i] = (i >= 2) && (holds < 20) && ($urandom_range(0, 99) < pct);
      if (hold_plan[i]) holds++;
    end
  endtask

  task automatic check_drained(input string nm);
    chk({nm, "_pix_left"}, pix_q.size(), 0);
    chk({nm, "_rst_left"}, rst_q.size(), 0);
    chk({nm, "_done_left"}, done_q.size(), 0);
    pix_q.delete(); rst_q.delete(); done_q.delete();
  endtask

  // fin_mode 0: Output_Finish fin_off edges after the Input_Finish cycle
  // fin_mode 1: Output_Finish during STREAM; fin_mode 2: never
  task automatic run_frame(input int fin_mode, input int fin_off, input bit junk);
    int  k, l, f, d, e_err, last, t;
    int  ptime [N];
    bit  exp_done;
    k = cyc + 1;
    t = k + 1;
    ptime[0] = t;
    for (int i = 1; i < N; i++) begin
      t++;
      while (hold_plan[t - k]) t++;
      ptime[i] = t;
    end
    l = t;
    rst_q.push_back(k);
    for (int i = 0; i < N; i++)
      pix_q.push_back('{pix: ref_mem[i], fin: (i == N - 1), t: ptime[i]});
    f = -1; d = 0; e_err = 0;
    if (fin_mode == 1) begin
      f = k + 2 + (fin_off % (l - k - 1));
      exp_done = 1'b1; d = l + 1;
    end else if (fin_mode == 0 && fin_off >= 1 && fin_off <= TMO) begin
      f = l + fin_off;
      exp_done = 1'b1; d = f;
    end else begin
      if (fin_mode == 0) f = l + fin_off;
      exp_done = 1'b0; e_err = l + TMO;
    end
    if (exp_done) begin
      done_q.push_back(d);
      last = d + 1;
    end else begin
      last = e_err;
    end
    for (int e = k; e <= last; e++) begin
      start = (e == k) || (junk && e > k && e <= l && $urandom_range(0, 2) == 0);
      hold  = (e >= k + 2 && e <= l) ? hold_plan[e - k] : 1'($urandom_range(0, 1));
      Output_Finish = (e == f);
      if (junk && e > k && e <= l) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, 31));
        wr_data = DW'($urandom);
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (e == k) begin
        chk("busy_at_reset", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);
      end
    end
    start = 1'b0; hold = 1'b0; Output_Finish = 1'b0; wr_en = 1'b0;
    chk("busy_end", 32'(busy), 32'd0);
    chk("err_end", 32'(err), 32'(!exp_done));
    chk("done_end", 32'(done), 32'd0);
    check_drained("frame");
  endtask

  // Starts a no-hold frame and asserts reset while pixel 7 is on the bus.
  task automatic run_reset_frame();
    int k;
    k = cyc + 1;
    rst_q.push_back(k);
    for (int i = 0; i < 8; i++)
      pix_q.push_back('{pix: ref_mem[i], fin: 1'b0, t: k + 1 + i});
    for (int e = k; e <= k + 8; e++) begin
      start = (e == k);
      hold  = (e >= k + 2) ? 1'b0 : 1'($urandom_range(0, 1));
      Output_Finish = 1'b0;
      step();
    end
    start = 1'b0;
    h_rst_n = 1'b0;
    step();
    chk("rst_pixel", 32'(Input_Pixel), 32'd0);
    chk("rst_valid", 32'(Input_Valid), 32'd0);
    chk("rst_finish", 32'(Input_Finish), 32'd0);
    chk("rst_ireset", 32'(Input_Reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    h_rst_n = 1'b1;
    check_drained("abort");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    h_rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; hold = 1'b0; Output_Finish = 1'b0;
    for (int i = 0; i < 64; i++) hold_plan[i] = 1'b0;
    repeat (3) step();
    chk("reset_pixel", 32'(Input_Pixel), 32'd0);
    chk("reset_valid", 32'(Input_Valid), 32'd0);
    chk("reset_finish", 32'(Input_Finish), 32'd0);
    chk("reset_ireset", 32'(Input_Reset), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    h_rst_n = 1'b1;
    step();

    for (int a = 0; a < N; a++) host_wr(a, DW'(16'h0100 + a));
    host_wr(16, 16'hDEAD);
    host_wr(31, 16'hBEEF);
    idle(2);

    // plain frame, Output_Finish 5 cycles after Input_Finish
    gen_hold(0);
    run_frame(0, 5, 1'b0);
    idle(2);

    // three held cycles right after pixel 5
    gen_hold(0);
    hold_plan[7] = 1'b1; hold_plan[8] = 1'b1; hold_plan[9] = 1'b1;
    run_frame(0, 5, 1'b0);
    idle(1);

    // early Output_Finish during STREAM, then a timeout, then recovery
    gen_hold(0);
    run_frame(1, 4, 1'b0);
    idle(1);
    run_frame(2, 0, 1'b0);
    idle(2);
    run_frame(0, 1, 1'b0);
    idle(1);

    // writes and start while busy must not disturb the frame or the buffer
    gen_hold(20);
    run_frame(0, 3, 1'b1);
    idle(1);
    gen_hold(0);
    run_frame(0, 2, 1'b0);
    idle(1);

    // reset mid-frame, then a full replay from the retained buffer
    run_reset_frame();
    idle(1);
    run_frame(0, 3, 1'b0);
    idle(1);

    for (int it = 0; it < 12; it++) begin
      int mode, off;
      if ($urandom_range(0, 2) == 0) begin
        for (int w = 0; w < 24; w++)
          host_wr(int'($urandom_range(0, 31)), DW'($urandom));
      end
      gen_hold(int'($urandom_range(0, 40)));
      mode = int'($urandom_range(0, 2));
      if (mode == 0)
        off = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : int'($urandom_range(9, 12));
      else
        off = int'($urandom_range(0, 40));
      run_frame(mode, off, 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
